// File: rtl/qcldpc_pkg.sv
// Shared types and helpers for the QC-LDPC encoder control path.
package qcldpc_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} seq_state_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // ROM rows per Z: every block-column against every parity block-row
    function automatic int zbase(input int ninfo, input int npar);
        return (ninfo + npar) * npar;
    endfunction

    function automatic int rom_depth(input int ninfo, input int npar, input int nz);
        return zbase(ninfo, npar) * nz;
    endfunction

    function automatic int onehot_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/qcldpc_tag_pipe.sv
// Fixed-latency delay line with synchronous clear; matches the shifter pipeline depth.
module qcldpc_tag_pipe #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stg;

    always_ff @(posedge CLK) begin
        if (clr) begin
            stg <= '0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stg[i] <= stg[i-1];
        end
    end

    assign dout = stg[DEPTH-1];

endmodule

// File: rtl/qcldpc_enc_sequencer.sv
// Control sequencer for the QC-LDPC encoder datapath.
// Optional stall counter output enabled by QCLDPC_SEQ_STALL_CNT_EN.
module qcldpc_enc_sequencer
    import qcldpc_pkg::*;
#(
    parameter int NUM_Z           = 3,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int PAR             = 1,
    parameter int SHIFT_LAT       = 7,
    localparam int NCOL      = NUM_INFO_BLKS / PAR,
    localparam int ZBASE     = zbase(NUM_INFO_BLKS, NUM_PARITY_BLKS),
    localparam int ROM_DEPTH = rom_depth(NUM_INFO_BLKS, NUM_PARITY_BLKS, NUM_Z),
    localparam int ADDRW     = $clog2(ROM_DEPTH),
    localparam int STEP      = NUM_PARITY_BLKS * PAR,
    localparam int CW        = (NCOL > 1) ? $clog2(NCOL) : 1,
    localparam int ZW        = (NUM_Z > 1) ? $clog2(NUM_Z) : 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_Z-1:0] req_z,
    output logic             busy,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NUM_Z-1:0] z_sel,
    output logic [ADDRW-1:0] rom_addr,
    output logic             shf_valid,
    output logic [CW-1:0]    col_idx,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done
`ifdef QCLDPC_SEQ_STALL_CNT_EN
   ,output logic [15:0]      stall_cnt
`endif
);

    if (NUM_INFO_BLKS % PAR != 0) begin : g_par_chk
        $fatal(1, "NUM_INFO_BLKS must be a multiple of PAR");
    end
    if (SHIFT_LAT < 1) begin : g_lat_chk
        $fatal(1, "SHIFT_LAT must be at least 1");
    end

    seq_state_t      state, state_n;
    logic [CW-1:0]   col;
    logic [ZW-1:0]   z_idx;
    tag_t            tag_in, tag_out;
    logic            blk_go, last_col;

    assign blk_go    = (state == IDLE) && start && $onehot(req_z);
    assign last_col  = (col == CW'(NCOL - 1));
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUTPUT);
    assign shf_valid = in_valid && in_ready;
    assign col_idx   = col;
    assign rom_addr  = ADDRW'(ZBASE * int'(z_idx) + STEP * int'(col));

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            IDLE:   if (blk_go) state_n = ISSUE;
            ISSUE: begin
                in_ready = 1'b1;
                if (in_valid && last_col) state_n = DRAIN;
            end
            DRAIN:  if (tag_out.valid && tag_out.last) state_n = OUTPUT;
            OUTPUT: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // col wraps to 0 after the last beat so DRAIN/OUTPUT present the Z base address
    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= IDLE;
            col     <= '0;
            z_idx   <= '0;
            z_sel   <= '0;
            cfg_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cfg_err <= (state == IDLE) && start && !$onehot(req_z);
            done    <= (state == OUTPUT) && out_ready;
            if (blk_go) begin
                z_sel <= req_z;
                z_idx <= ZW'(onehot_idx(32'(req_z)));
                col   <= '0;
            end else if (shf_valid) begin
                col <= last_col ? '0 : col + CW'(1);
            end
        end
    end

    assign tag_in = '{valid: shf_valid, first: (col == '0), last: last_col};

    qcldpc_tag_pipe #(
        .DEPTH (SHIFT_LAT),
        .WIDTH ($bits(tag_t))
    ) u_tag_pipe (
        .CLK  (CLK),
        .clr  (rst),
        .din  (tag_in),
        .dout (tag_out)
    );

    assign acc_en    = tag_out.valid;
    assign acc_clear = tag_out.valid && tag_out.first;

`ifdef QCLDPC_SEQ_STALL_CNT_EN
    always_ff @(posedge CLK) begin
        if (rst || blk_go)
            stall_cnt <= '0;
        else if (state == ISSUE && !in_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_qcldpc_enc_sequencer.sv
// Randomized + directed bench for qcldpc_enc_sequencer against a cycle-trace model.
module tb_qcldpc_enc_sequencer;

    localparam int NZ = 3, NIB = 20, NPB = 4, PAR = 1, SL = 7;
    localparam int NCOL = NIB / PAR, ZB = (NIB + NPB) * NPB, STEP = NPB * PAR;
    localparam int AW = 9, CW = 5, MAXC = 16384;

    logic CLK = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [NZ-1:0] req_z = '0;
    logic busy, cfg_err, in_ready, shf_valid, acc_clear, acc_en, out_valid, done;
    logic [NZ-1:0] z_sel;
    logic [AW-1:0] rom_addr;
    logic [CW-1:0] col_idx;
`ifdef QCLDPC_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    qcldpc_enc_sequencer #(
        .NUM_Z(NZ), .NUM_INFO_BLKS(NIB), .NUM_PARITY_BLKS(NPB), .PAR(PAR), .SHIFT_LAT(SL)
    ) dut (
        .CLK(CLK), .rst(rst), .start(start), .req_z(req_z), .busy(busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .z_sel(z_sel), .rom_addr(rom_addr),
        .shf_valid(shf_valid), .col_idx(col_idx), .acc_clear(acc_clear), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready), .done(done)
`ifdef QCLDPC_SEQ_STALL_CNT_EN
       ,.stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0;
    // model: phase 0 idle, 1 issuing, 2 waiting for last data, 3 parity held
    int ph = 0, mz = 0, mcol = 0, mstall = 0;
    logic [NZ-1:0] mzsel = '0;
    bit mcfg = 0, mdone = 0;
    bit hv[MAXC], hf[MAXC], hl[MAXC];
    int beat_cyc[$], beat_addr[$], acc_cyc[$], clr_cyc[$], ov_cyc[$], done_cyc[$], cfg_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic clr_log();
        beat_cyc.delete(); beat_addr.delete(); acc_cyc.delete(); clr_cyc.delete();
        ov_cyc.delete(); done_cyc.delete(); cfg_cyc.delete();
    endtask

    task automatic step();
        bit e_acc, e_last;
        int zi;
        @(negedge CLK);
        e_acc  = (cyc >= SL) && hv[cyc-SL];
        e_last = e_acc && hl[cyc-SL];
        chk("busy", busy, ph != 0);
        chk("in_ready", in_ready, ph == 1);
        chk("shf_valid", shf_valid, (ph == 1) && in_valid);
        chk("rom_addr", rom_addr, mz * ZB + mcol * STEP);
        chk("col_idx", col_idx, mcol);
        chk("z_sel", z_sel, mzsel);
        chk("acc_en", acc_en, e_acc);
        chk("acc_clear", acc_clear, e_acc && hf[cyc-SL]);
        chk("out_valid", out_valid, ph == 3);
        chk("done", done, mdone);
        chk("cfg_err", cfg_err, mcfg);
`ifdef QCLDPC_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, mstall);
`endif
        if (shf_valid) begin beat_cyc.push_back(cyc); beat_addr.push_back(int'(rom_addr)); end
        if (acc_en) acc_cyc.push_back(cyc);
        if (acc_clear) clr_cyc.push_back(cyc);
        if (out_valid) ov_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (cfg_err) cfg_cyc.push_back(cyc);
        hv[cyc] = (ph == 1) && in_valid;
        hf[cyc] = (mcol == 0);
        hl[cyc] = (mcol == NCOL - 1);
        @(posedge CLK);
        if (rst) begin
            ph = 0; mz = 0; mcol = 0; mzsel = '0; mcfg = 0; mdone = 0; mstall = 0;
            for (int k = cyc - SL + 1; k <= cyc; k++) if (k >= 0) hv[k] = 0;
        end else begin
            mcfg  = (ph == 0) && start && !$onehot(req_z);
            mdone = (ph == 3) && out_ready;
            case (ph)
                0: if (start && $onehot(req_z)) begin
                       zi = 0;
                       for (int i = 0; i < NZ; i++) if (req_z[i]) zi = i;
                       mz = zi; mzsel = req_z; mcol = 0; mstall = 0; ph = 1;
                   end
                1: if (in_valid) begin
                       if (mcol == NCOL - 1) begin mcol = 0; ph = 2; end
                       else mcol++;
                   end else if (mstall < 65535) mstall++;
                2: if (e_last) ph = 3;
                default: if (out_ready) ph = 0;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic wait_ov(input int lim);
        int k;
        k = 0;
        while (!out_valid && k < lim) begin step(); k++; end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic finish_blk();
        in_valid = 1;
        wait_ov(60);
        in_valid = 0; out_ready = 1; step(); out_ready = 0; step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; step(); step(); rst = 0;
        chk("reset_busy", busy, 0);
        chk("reset_addr", rom_addr, 0);

        // back-to-back block on the largest Z
        clr_log(); start = 1; req_z = 3'b100; step(); start = 0; in_valid = 1;
        repeat (20) step();
        in_valid = 0;
        wait_ov(30);
        chk("t1_beats", beat_cyc.size(), 20);
        chk("t1_accs", acc_cyc.size(), 20);
        chk("t1_clears", clr_cyc.size(), 1);
        if (beat_cyc.size() == 20 && acc_cyc.size() == 20 && clr_cyc.size() == 1 && ov_cyc.size() > 0) begin
            for (int i = 0; i < 20; i++) chk("t1_addr", beat_addr[i], 192 + 4 * i);
            chk("t1_last_addr", beat_addr[19], 268);
            chk("t1_acc_lat", acc_cyc[0] - beat_cyc[0], 7);
            chk("t1_clr_first", clr_cyc[0], acc_cyc[0]);
            chk("t1_ov_lat", ov_cyc[0] - beat_cyc[19], 8);
        end

        // parity held while downstream stalls; start ignored meanwhile
        start = 1; req_z = 3'b001; repeat (5) step(); start = 0;
        chk("t4_ov_held", out_valid, 1);
        chk("t4_busy_held", busy, 1);
        clr_log(); out_ready = 1; step(); out_ready = 0; step();
        chk("t4_done_once", done_cyc.size(), 1);
        chk("t4_idle", busy, 0);
        chk("t4_no_cfg", cfg_cyc.size(), 0);

        // bubbles on every other cycle, Z index 0
        clr_log(); start = 1; req_z = 3'b001; step(); start = 0;
        for (int i = 0; i < 40; i++) begin in_valid = (i % 2 == 0); step(); end
        in_valid = 0;
        wait_ov(30);
        chk("t2_beats", beat_cyc.size(), 20);
        if (beat_cyc.size() == 20 && acc_cyc.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("t2_addr", beat_addr[i], 4 * i);
                chk("t2_acc_cyc", acc_cyc[i], beat_cyc[i] + 7);
            end
        end
        out_ready = 1; step(); out_ready = 0; step();

        // illegal Z request, then a legal one
        clr_log(); start = 1; req_z = 3'b011; step(); start = 0; step();
        chk("t3_cfg_err", cfg_cyc.size(), 1);
        chk("t3_busy", busy, 0);
        start = 1; req_z = 3'b010; step(); start = 0; in_valid = 1; step();
        chk("t3_beats", beat_addr.size(), 1);
        if (beat_addr.size() == 1) chk("t3_addr96", beat_addr[0], 96);
        finish_blk();

        // reset in the middle of a block
        clr_log(); start = 1; req_z = 3'b001; step(); start = 0; in_valid = 1;
        repeat (10) step();
        chk("t5_col10", col_idx, 10);
        rst = 1; step(); rst = 0; in_valid = 0;
        clr_log(); repeat (8) step();
        chk("t5_no_acc", acc_cyc.size(), 0);
        chk("t5_idle", busy, 0);
        start = 1; req_z = 3'b001; step(); start = 0; in_valid = 1; step();
        if (beat_addr.size() > 0) chk("t5_addr0", beat_addr[0], 0);
        else chk("t5_beat", beat_addr.size(), 1);
        finish_blk();

`ifdef QCLDPC_SEQ_STALL_CNT_EN
        start = 1; req_z = 3'b010; step(); start = 0; in_valid = 0;
        repeat (3) step();
        chk("t6_stall3", stall_cnt, 3);
        finish_blk();
        chk("t6_stall_hold", stall_cnt, 3);
        start = 1; req_z = 3'b001; step(); start = 0;
        chk("t6_stall_clr", stall_cnt, 0);
        finish_blk();
`endif

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 7);
            start = ($urandom_range(0, 3) == 0);
            req_z = (r < 6) ? 3'(1 << (r % 3)) : ((r == 6) ? 3'b000 : 3'b110);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0; start = 0; in_valid = 0; out_ready = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
